// File: rtl/inertial_pkg.sv
// Shared types and default constants for the inertial pitch integrator.
package inertial_pkg;

   typedef enum logic {RUN = 1'b0, CAL = 1'b1} state_t;

   localparam int              RT_W_DEF        = 16;
   localparam int              ACC_W_DEF       = 27;
   localparam int              OUT_SHIFT_DEF   = 11;
   localparam int              FUSION_STEP_DEF = 1024;
   localparam int              AZ_GAIN_DEF     = 327;
   localparam int              AZ_SHIFT_DEF    = 13;
   localparam int              CAL_LOG2_DEF    = 8;
   localparam logic [15:0]     RT_OFF_RST      = 16'h0050;
   localparam logic [15:0]     AZ_OFF_RST      = 16'h00A0;

   // Width of AZ_GAIN as a signed operand.
   function automatic int gain_w(input int gain);
      return $clog2(gain + 1) + 1;
   endfunction

endpackage

// File: rtl/inertial_cal_avg.sv
// Offset calibration: sums 2^CAL_LOG2 samples of each axis and loads the mean as the new offset.
module inertial_cal_avg
   import inertial_pkg::*;
#(
   parameter int              RT_W       = RT_W_DEF,
   parameter int              CAL_LOG2   = CAL_LOG2_DEF,
   parameter logic [RT_W-1:0] RT_OFF_DEF = RT_OFF_RST,
   parameter logic [RT_W-1:0] AZ_OFF_DEF = AZ_OFF_RST
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   smp,
   input  logic signed [RT_W-1:0] ptch_rt,
   input  logic signed [RT_W-1:0] az,
   output logic                   last,
   output logic signed [RT_W-1:0] rt_off,
   output logic signed [RT_W-1:0] az_off
);

   localparam int SUM_W = RT_W + CAL_LOG2;

   logic signed [SUM_W-1:0] rt_sum, az_sum, rt_sum_nxt, az_sum_nxt;
   logic [CAL_LOG2-1:0]     cnt;

   assign rt_sum_nxt = rt_sum + SUM_W'(ptch_rt);
   assign az_sum_nxt = az_sum + SUM_W'(az);
   assign last       = smp && (cnt == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rt_sum <= '0;
         az_sum <= '0;
         cnt    <= '0;
         rt_off <= RT_OFF_DEF;
         az_off <= AZ_OFF_DEF;
      end else if (clr) begin
         rt_sum <= '0;
         az_sum <= '0;
         cnt    <= '0;
      end else if (smp) begin
         if (last) begin
            // Upper slice of the full sum is the arithmetic mean.
            rt_off <= rt_sum_nxt[SUM_W-1:CAL_LOG2];
            az_off <= az_sum_nxt[SUM_W-1:CAL_LOG2];
            rt_sum <= '0;
            az_sum <= '0;
            cnt    <= '0;
         end else begin
            rt_sum <= rt_sum_nxt;
            az_sum <= az_sum_nxt;
            cnt    <= cnt + CAL_LOG2'(1);
         end
      end
   end

endmodule

// File: rtl/inertial_integrator_cal.sv
// Pitch integrator fusing gyro rate with accelerometer pitch, with on-demand offset calibration.
module inertial_integrator_cal
   import inertial_pkg::*;
#(
   parameter int              RT_W        = RT_W_DEF,
   parameter int              ACC_W       = ACC_W_DEF,
   parameter int              OUT_SHIFT   = OUT_SHIFT_DEF,
   parameter int              FUSION_STEP = FUSION_STEP_DEF,
   parameter int              AZ_GAIN     = AZ_GAIN_DEF,
   parameter int              AZ_SHIFT    = AZ_SHIFT_DEF,
   parameter int              CAL_LOG2    = CAL_LOG2_DEF,
   parameter logic [RT_W-1:0] RT_OFF_DEF  = RT_OFF_RST,
   parameter logic [RT_W-1:0] AZ_OFF_DEF  = AZ_OFF_RST
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   vld,
   input  logic signed [RT_W-1:0] ptch_rt,
   input  logic signed [RT_W-1:0] AZ,
   input  logic                   cal_start,
   output logic signed [RT_W-1:0] ptch,
   output logic                   ptch_vld,
   output logic                   cal_busy,
   output logic                   cal_done
);

   localparam int GAIN_W = gain_w(AZ_GAIN);
   localparam int PROD_W = RT_W + 1 + GAIN_W;
   localparam int STAGES = 1;

   localparam logic signed [GAIN_W-1:0] GAIN_S  = GAIN_W'(AZ_GAIN);
   localparam logic signed [PROD_W-1:0] PA_MAX  = {{(PROD_W-RT_W+1){1'b0}}, {(RT_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] PA_MIN  = {{(PROD_W-RT_W+1){1'b1}}, {(RT_W-1){1'b0}}};
   localparam logic signed [ACC_W+1:0]  ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W+1:0]  ACC_MIN = {3'b111, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W+1:0]  FS      = (ACC_W+2)'(FUSION_STEP);

   state_t state, state_nxt;
   logic   cal_clr, cal_smp, cal_last, run_vld, acc_clr;

   logic signed [RT_W-1:0]   rt_off, az_off;
   logic signed [RT_W:0]     rate_comp, az_diff;
   logic signed [PROD_W-1:0] az_prod, az_shr;
   logic signed [RT_W-1:0]   ptch_acc;
   logic signed [ACC_W+1:0]  step, acc_sum;
   logic signed [ACC_W-1:0]  acc, acc_sat;
   logic [STAGES:0]          vld_pipe;

   inertial_cal_avg #(
      .RT_W       (RT_W),
      .CAL_LOG2   (CAL_LOG2),
      .RT_OFF_DEF (RT_OFF_DEF),
      .AZ_OFF_DEF (AZ_OFF_DEF)
   ) u_cal (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (cal_clr),
      .smp     (cal_smp),
      .ptch_rt (ptch_rt),
      .az      (AZ),
      .last    (cal_last),
      .rt_off  (rt_off),
      .az_off  (az_off)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN: if (cal_start)             state_nxt = CAL;
         CAL: if (!cal_start && cal_last) state_nxt = RUN;
         default:                        state_nxt = RUN;
      endcase
   end

   // cal_start wins over a coincident vld in either state.
   always_comb begin
      cal_busy = (state == CAL);
      cal_clr  = cal_start;
      cal_smp  = (state == CAL) && vld && !cal_start;
      run_vld  = (state == RUN) && vld && !cal_start;
      acc_clr  = (state == CAL) || cal_start;
   end

   assign rate_comp = (RT_W+1)'(ptch_rt) - (RT_W+1)'(rt_off);
   assign az_diff   = (RT_W+1)'(AZ) - (RT_W+1)'(az_off);
   assign az_prod   = PROD_W'(az_diff) * PROD_W'(GAIN_S);
   assign az_shr    = az_prod >>> AZ_SHIFT;
   assign ptch_acc  = (az_shr > PA_MAX) ? {1'b0, {(RT_W-1){1'b1}}} :
                      (az_shr < PA_MIN) ? {1'b1, {(RT_W-1){1'b0}}} : az_shr[RT_W-1:0];

   assign step    = (ptch_acc > ptch) ? FS : -FS;
   assign acc_sum = (ACC_W+2)'(acc) - (ACC_W+2)'(rate_comp) + step;
   assign acc_sat = (acc_sum > ACC_MAX) ? {1'b0, {(ACC_W-1){1'b1}}} :
                    (acc_sum < ACC_MIN) ? {1'b1, {(ACC_W-1){1'b0}}} : acc_sum[ACC_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         ptch     <= '0;
         vld_pipe <= '0;
         cal_done <= 1'b0;
      end else begin
         cal_done <= cal_last;
         if (acc_clr) begin
            acc      <= '0;
            ptch     <= '0;
            vld_pipe <= '0;
         end else begin
            if (run_vld) acc <= acc_sat;
            ptch     <= acc[ACC_W-1:OUT_SHIFT];
            vld_pipe <= {vld_pipe[STAGES-1:0], run_vld};
         end
      end
   end

   assign ptch_vld = vld_pipe[STAGES];

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// Randomised and directed bench with a reference model and a scoreboard monitor.
module tb_inertial_integrator_cal;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               vld = 1'b0;
   logic        [15:0] ptch_rt = '0;
   logic        [15:0] AZ = '0;
   logic               cal_start = 1'b0;
   logic signed [15:0] ptch;
   logic               ptch_vld, cal_busy, cal_done;

   inertial_integrator_cal dut (
      .clk(clk), .rst_n(rst_n), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ),
      .cal_start(cal_start), .ptch(ptch), .ptch_vld(ptch_vld),
      .cal_busy(cal_busy), .cal_done(cal_done)
   );

   always #5 clk = ~clk;

   typedef struct {int val; int cyc;} exp_t;
   exp_t edq[$];
   int   cdq[$];

   int n_chk = 0, n_fail = 0, cyc = 0, tid = 0;
   bit mon_en = 1'b0;

   // reference model state
   bit     m_cal, pend_v;
   int     m_acc, m_ptch, m_rt_off, m_az_off, m_cnt, pend_val;
   longint m_sum_rt, m_sum_az;

   task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int sx(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction

   task automatic model_reset();
      m_cal = 0; pend_v = 0; m_acc = 0; m_ptch = 0; m_cnt = 0;
      m_rt_off = 'h50; m_az_off = 'hA0; m_sum_rt = 0; m_sum_az = 0;
      edq.delete(); cdq.delete();
   endtask

   // One clock edge of the specified behaviour, using the inputs present at that edge.
   task automatic model_step();
      int  rt = sx(ptch_rt), az = sx(AZ);
      int  old_acc = m_acc, old_ptch = m_ptch;
      int  rate, pa, na;
      bit  flush = m_cal || cal_start;
      if (pend_v && !flush) edq.push_back('{pend_val, cyc});
      pend_v = 0;
      if (!m_cal) begin
         if (cal_start) begin
            m_cal = 1; m_cnt = 0; m_sum_rt = 0; m_sum_az = 0; m_acc = 0; m_ptch = 0;
         end else begin
            m_ptch = old_acc >>> 11;
            if (vld) begin
               rate = rt - m_rt_off;
               pa   = clamp(((az - m_az_off) * 327) >>> 13, -32768, 32767);
               na   = clamp(old_acc - rate + ((pa > old_ptch) ? 1024 : -1024), -(1 << 26), (1 << 26) - 1);
               m_acc = na; pend_v = 1; pend_val = na >>> 11;
            end
         end
      end else begin
         m_acc = 0; m_ptch = 0;
         if (cal_start) begin
            m_cnt = 0; m_sum_rt = 0; m_sum_az = 0;
         end else if (vld) begin
            m_sum_rt += rt; m_sum_az += az; m_cnt++;
            if (m_cnt == 256) begin
               m_rt_off = int'(m_sum_rt >>> 8);
               m_az_off = int'(m_sum_az >>> 8);
               m_cal = 0; m_cnt = 0;
               cdq.push_back(cyc);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst_n) model_step();
      #1;
   endtask

   task automatic do_reset();
      vld = 0; cal_start = 0;
      rst_n = 0;
      model_reset();
      @(negedge clk);
      chk(ptch == 0,     "rst_ptch",     ptch, 0);
      chk(!ptch_vld,     "rst_ptch_vld", ptch_vld, 0);
      chk(!cal_busy,     "rst_cal_busy", cal_busy, 0);
      chk(!cal_done,     "rst_cal_done", cal_done, 0);
      chk(int'(dut.rt_off) == 'h50, "rst_rt_off", dut.rt_off, 'h50);
      chk(int'(dut.az_off) == 'hA0, "rst_az_off", dut.az_off, 'hA0);
      @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic run_vld(input int n, input logic [15:0] rt, input logic [15:0] az);
      ptch_rt = rt; AZ = az;
      for (int i = 0; i < n; i++) begin
         vld = 1; tick();
      end
      vld = 0;
   endtask

   // Scoreboard: pops expected events whenever the DUT presents them.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && mon_en) begin
         chk(cal_busy == m_cal, "cal_busy", cal_busy, m_cal);
         if (cal_busy) chk(ptch == 0 && !ptch_vld, "cal_hold", ptch, 0);
         if (ptch_vld) begin
            if (edq.size() == 0) chk(0, "ptch_vld_unexpected", 1, 0);
            else begin
               e = edq.pop_front();
               chk(e.cyc == cyc, "ptch_latency", cyc, e.cyc);
               chk(int'(ptch) == e.val, "ptch_value", ptch, e.val);
               if (tid == 1) chk(ptch == 0 || ptch == -1, "ptch_idle_range", ptch, 0);
               if (tid == 4) chk(ptch >= 0, "ptch_no_wrap", ptch, 32767);
            end
         end else if (edq.size() > 0 && edq[0].cyc <= cyc) begin
            chk(0, "ptch_vld_missing", 0, edq[0].cyc);
            void'(edq.pop_front());
         end
         if (cal_done) begin
            if (cdq.size() == 0) chk(0, "cal_done_unexpected", 1, 0);
            else chk(cdq.pop_front() == cyc, "cal_done_cycle", cyc, 0);
         end else if (cdq.size() > 0 && cdq[0] <= cyc) begin
            chk(0, "cal_done_missing", 0, cdq[0]);
            void'(cdq.pop_front());
         end
      end
   end

   initial begin
      model_reset();
      tick();
      do_reset();
      mon_en = 1;

      tid = 1;
      run_vld(50, 16'h0050, 16'h00A0);
      repeat (3) tick();

      tid = 3;
      do_reset();
      run_vld(400, 16'hFC50, 16'h20A0);
      repeat (3) tick();
      chk(ptch >= 326 && ptch <= 328, "ptch_settle_327", ptch, 327);

      tid = 4;
      do_reset();
      run_vld(2500, 16'h8000, 16'h80A0);
      repeat (3) tick();
      chk(ptch == 16'sh7FFF, "ptch_saturate", ptch, 32767);

      tid = 5;
      cal_start = 1; tick(); cal_start = 0;
      for (int i = 0; i < 256; i++) begin
         ptch_rt = 16'h0123; AZ = 16'h0040;
         vld = ($urandom_range(0, 3) != 0) || (i == 255);
         tick();
         if (!vld) i--;
      end
      vld = 0;
      repeat (2) tick();
      chk(int'(dut.rt_off) == 'h123, "cal_rt_off", dut.rt_off, 'h123);
      chk(int'(dut.az_off) == 'h40,  "cal_az_off", dut.az_off, 'h40);
      run_vld(20, 16'h0123, 16'h0040);
      repeat (3) tick();

      tid = 6;
      cal_start = 1; tick(); cal_start = 0;
      run_vld(100, 16'h1111, 16'h2222);
      do_reset();
      chk(!cal_busy, "abort_cal_busy", cal_busy, 0);
      cal_start = 1; tick(); cal_start = 0;
      run_vld(255, 16'h0200, 16'h0300);
      repeat (2) tick();
      chk(cal_busy, "fresh_cal_still_busy", cal_busy, 1);
      run_vld(1, 16'h0200, 16'h0300);
      repeat (2) tick();
      chk(!cal_busy, "fresh_cal_done", cal_busy, 0);

      tid = 7;
      run_vld(5, 16'h0200, 16'h0300);
      cal_start = 1; vld = 1; tick(); cal_start = 0; vld = 0;
      tick();
      run_vld(256, 16'hFFF0, 16'h0010);
      repeat (3) tick();

      tid = 8;
      for (int i = 0; i < 4000; i++) begin
         vld       = $urandom_range(0, 1);
         cal_start = ($urandom_range(0, 599) == 0);
         ptch_rt   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom_range(0, 65535));
         AZ        = 16'($urandom_range(0, 65535));
         tick();
      end
      vld = 0; cal_start = 0;
      repeat (4) tick();
      chk(edq.size() == 0, "ptch_queue_drained", edq.size(), 0);
      chk(cdq.size() == 0, "cal_queue_drained",  cdq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
